// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the fetch/data single-port memory arbiter: bus structs,
// FSM and grant encodings, and default tuning constants.
package mem_port_arbiter_pkg;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int SEL_W  = 4;

  localparam int STARVE_MAX_DEF  = 4;
  localparam int TIMEOUT_CYC_DEF = 16;

  localparam logic [SEL_W-1:0] FETCH_SEL = 4'b1111;

  typedef enum logic [1:0] {ARB_IDLE, ARB_ISSUE, ARB_WAIT} type_arb_state_e;
  typedef enum logic [1:0] {GNT_NONE, GNT_IF, GNT_DATA}    type_arb_gnt_e;

  typedef struct packed {
    logic              req;
    logic [ADDR_W-1:0] addr;
  } type_if2mem_s;

  typedef struct packed {
    logic [DATA_W-1:0] r_data;
    logic              ack;
  } type_mem2if_s;

  typedef struct packed {
    logic              req;
    logic [ADDR_W-1:0] addr;
    logic              w_en;
    logic [DATA_W-1:0] w_data;
    logic [SEL_W-1:0]  sel_byte;
  } type_dbus2peri_s;

  typedef struct packed {
    logic [DATA_W-1:0] r_data;
    logic              ack;
  } type_peri2dbus_s;

endpackage

// File: rtl/mem_arb_prio.sv
// Winner select for the memory arbiter: data has fixed priority unless fetch
// has been passed over STARVE_MAX times in a row or data is idle.
module mem_arb_prio
  import mem_port_arbiter_pkg::*;
#(
  parameter int STARVE_MAX = STARVE_MAX_DEF,
  parameter int CNT_W      = $clog2(STARVE_MAX + 1)
) (
  input  logic          i_d_req,
  input  logic          i_i_req,
  input  logic [CNT_W-1:0] i_starve_cnt,
  output type_arb_gnt_e o_gnt
);

  logic w_starved;

  assign w_starved = (i_starve_cnt == CNT_W'(STARVE_MAX));

  always_comb begin
    o_gnt = GNT_NONE;
    if (i_i_req && (w_starved || !i_d_req)) begin
      o_gnt = GNT_IF;
    end else if (i_d_req) begin
      o_gnt = GNT_DATA;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port slave between instruction fetch and the data bus:
// IDLE picks a winner, ISSUE pulses the slave request, WAIT forwards the ack.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int STARVE_MAX  = STARVE_MAX_DEF,
  parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  type_if2mem_s    if2arb_i,
  output type_mem2if_s    arb2if_o,
  input  logic            dmem_sel,
  input  type_dbus2peri_s exe2arb_i,
  output type_peri2dbus_s arb2exe_o,
  output type_dbus2peri_s arb2mem_o,
  input  type_peri2dbus_s mem2arb_i,
  output logic            bus_err_o
);

  localparam int CNT_W = $clog2(STARVE_MAX + 1);
  localparam int TMO_W = $clog2(TIMEOUT_CYC);

  type_arb_state_e   r_state;
  type_arb_state_e   w_state_nxt;
  type_arb_gnt_e     r_gnt;
  type_arb_gnt_e     w_win;
  logic [CNT_W-1:0]  r_starve_cnt;
  logic [TMO_W-1:0]  r_tmo_cnt;
  type_dbus2peri_s   r_req;
  type_dbus2peri_s   w_latch;
  logic              r_bus_err;

  logic              w_d_req;
  logic              w_i_req;
  logic              w_tmo_hit;
  logic              w_done;
  logic [DATA_W-1:0] w_rdata;

  assign w_d_req   = exe2arb_i.req & dmem_sel;
  assign w_i_req   = if2arb_i.req;
  assign w_tmo_hit = (r_tmo_cnt == TMO_W'(TIMEOUT_CYC - 1));

  mem_arb_prio #(
    .STARVE_MAX (STARVE_MAX),
    .CNT_W      (CNT_W)
  ) u_prio (
    .i_d_req      (w_d_req),
    .i_i_req      (w_i_req),
    .i_starve_cnt (r_starve_cnt),
    .o_gnt        (w_win)
  );

  // Fields captured from the winner; fetch is always a full-word read.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path infers a latch.
    w_latch = '0;
    if (w_win == GNT_IF) begin
      w_latch.addr     = if2arb_i.addr;
      w_latch.sel_byte = FETCH_SEL;
    end else if (w_win == GNT_DATA) begin
      w_latch     = exe2arb_i;
      w_latch.req = 1'b0;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_done      = 1'b0;
    w_rdata     = '0;
    case (r_state)
      ARB_IDLE:  if (w_win != GNT_NONE) w_state_nxt = ARB_ISSUE;
      ARB_ISSUE: w_state_nxt = ARB_WAIT;
      ARB_WAIT: begin
        if (mem2arb_i.ack) begin
          w_done      = 1'b1;
          w_rdata     = mem2arb_i.r_data;
          w_state_nxt = ARB_IDLE;
        end else if (w_tmo_hit) begin
          w_done      = 1'b1;
          w_state_nxt = ARB_IDLE;
        end
      end
      default:   w_state_nxt = ARB_IDLE;
    endcase
  end

  always_comb begin
    arb2if_o      = '0;
    arb2exe_o     = '0;
    arb2mem_o     = r_req;
    arb2mem_o.req = (r_state == ARB_ISSUE);
    if (w_done && (r_gnt == GNT_IF)) begin
      arb2if_o.ack    = 1'b1;
      arb2if_o.r_data = w_rdata;
    end
    if (w_done && (r_gnt == GNT_DATA)) begin
      arb2exe_o.ack    = 1'b1;
      arb2exe_o.r_data = w_rdata;
    end
  end

  assign bus_err_o = r_bus_err;

  always_ff @(posedge clk) begin
    // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      r_state      <= ARB_IDLE;
      r_gnt        <= GNT_NONE;
      r_starve_cnt <= '0;
      r_tmo_cnt    <= '0;
      // NOTE: the latched request is reset too, so the slave port shows zeros after reset.
      r_req        <= '0;
      r_bus_err    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      case (r_state)
        ARB_IDLE: begin
          if (w_win != GNT_NONE) begin
            r_gnt <= w_win;
            r_req <= w_latch;
            if ((w_win == GNT_DATA) && w_i_req) begin
              if (r_starve_cnt != CNT_W'(STARVE_MAX)) r_starve_cnt <= r_starve_cnt + CNT_W'(1);
            end else begin
              r_starve_cnt <= '0;
            end
          end
        end
        ARB_ISSUE: r_tmo_cnt <= '0;
        ARB_WAIT: begin
          if (w_done) r_gnt <= GNT_NONE;
          if (!mem2arb_i.ack) begin
            r_tmo_cnt <= r_tmo_cnt + TMO_W'(1);
            if (w_tmo_hit) r_bus_err <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // A granted requester must hold req until its ack.
  a_if_hold: assert property (@(posedge clk) disable iff (rst)
    ((r_state != ARB_IDLE) && (r_gnt == GNT_IF) && !arb2if_o.ack) |-> if2arb_i.req);

  a_data_hold: assert property (@(posedge clk) disable iff (rst)
    ((r_state != ARB_IDLE) && (r_gnt == GNT_DATA) && !arb2exe_o.ack) |-> exe2arb_i.req);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: a latency-programmable slave model,
// inputs driven and outputs sampled just after the falling edge.
module tb_mem_port_arbiter;
  import mem_port_arbiter_pkg::*;

  logic            clk = 1'b0;
  logic            rst;
  type_if2mem_s    if_req;
  type_mem2if_s    if_rsp;
  logic            dmem_sel;
  type_dbus2peri_s exe_req;
  type_peri2dbus_s exe_rsp;
  type_dbus2peri_s mem_req;
  type_peri2dbus_s mem_rsp;
  logic            bus_err;

  logic        mem_ack  = 1'b0;
  logic [31:0] slv_data = '0;
  int          slv_lat  = 1;
  int          slv_cnt  = 0;

  int n_checks = 0;
  int n_fail   = 0;

  assign mem_rsp = '{r_data: slv_data, ack: mem_ack};

  always #5 clk = ~clk;

  mem_port_arbiter dut (
    .clk       (clk),
    .rst       (rst),
    .if2arb_i  (if_req),
    .arb2if_o  (if_rsp),
    .dmem_sel  (dmem_sel),
    .exe2arb_i (exe_req),
    .arb2exe_o (exe_rsp),
    .arb2mem_o (mem_req),
    .mem2arb_i (mem_rsp),
    .bus_err_o (bus_err)
  );

  // Slave: acks slv_lat cycles after the req pulse; slv_lat=0 never acks.
  always @(negedge clk) begin
    mem_ack = 1'b0;
    if (slv_cnt > 0) begin
      slv_cnt = slv_cnt - 1;
      if (slv_cnt == 0) mem_ack = 1'b1;
    end
    if (mem_req.req) slv_cnt = slv_lat;
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic run_fetch(input logic [31:0] addr, input logic [31:0] data);
    slv_lat     = 1;
    slv_data    = data;
    if_req.addr = addr;
    if_req.req  = 1'b1;
    step();
    check("fetch_req_pulse", 32'(mem_req.req), 32'd1);
    check("fetch_addr", mem_req.addr, addr);
    check("fetch_wen", 32'(mem_req.w_en), 32'd0);
    check("fetch_sel", 32'(mem_req.sel_byte), 32'hF);
    check("fetch_no_ack_early", 32'(if_rsp.ack), 32'd0);
    step();
    check("fetch_req_drop", 32'(mem_req.req), 32'd0);
    check("fetch_ack", 32'(if_rsp.ack), 32'd1);
    check("fetch_rdata", if_rsp.r_data, data);
    check("fetch_exe_quiet", 32'(exe_rsp.ack), 32'd0);
    if_req.req = 1'b0;
    step();
    check("fetch_ack_once", 32'(if_rsp.ack), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bit found;
    rst      = 1'b1;
    if_req   = '0;
    exe_req  = '0;
    dmem_sel = 1'b0;
    step();
    step();
    check("rst_mem_req", 32'(mem_req.req), 32'd0);
    check("rst_mem_addr", mem_req.addr, 32'd0);
    check("rst_if_ack", 32'(if_rsp.ack), 32'd0);
    check("rst_exe_ack", 32'(exe_rsp.ack), 32'd0);
    check("rst_bus_err", 32'(bus_err), 32'd0);
    rst = 1'b0;
    step();

    // 1: single fetch
    run_fetch(32'h10, 32'h0050_0093);

    // 2: simultaneous fetch and data load, data first
    slv_data      = 32'h0000_BEEF;
    if_req.addr   = 32'h14;
    if_req.req    = 1'b1;
    dmem_sel      = 1'b1;
    exe_req       = '0;
    exe_req.addr  = 32'h200;
    exe_req.sel_byte = 4'hF;
    exe_req.req   = 1'b1;
    step();
    check("t2_data_first", mem_req.addr, 32'h200);
    check("t2_req", 32'(mem_req.req), 32'd1);
    step();
    check("t2_exe_ack", 32'(exe_rsp.ack), 32'd1);
    check("t2_exe_rdata", exe_rsp.r_data, 32'h0000_BEEF);
    check("t2_if_no_ack", 32'(if_rsp.ack), 32'd0);
    exe_req.req = 1'b0;
    step();
    check("t2_idle_no_req", 32'(mem_req.req), 32'd0);
    step();
    check("t2_fetch_addr", mem_req.addr, 32'h14);
    check("t2_fetch_req", 32'(mem_req.req), 32'd1);
    step();
    check("t2_if_ack", 32'(if_rsp.ack), 32'd1);
    check("t2_exe_no_ack", 32'(exe_rsp.ack), 32'd0);
    if_req.req = 1'b0;
    step();

    // 3: continuous stores and fetches, order D,D,D,D,I
    slv_data         = '0;
    if_req.addr      = 32'h40;
    if_req.req       = 1'b1;
    exe_req.addr     = 32'h300;
    exe_req.w_en     = 1'b1;
    exe_req.w_data   = 32'hAABB_CCDD;
    exe_req.sel_byte = 4'b0011;
    exe_req.req      = 1'b1;
    for (int k = 0; k < 10; k++) begin
      found = 1'b0;
      for (int c = 0; c < 6 && !found; c++) begin
        step();
        check("t3_ack_mutex", 32'(exe_rsp.ack & if_rsp.ack), 32'd0);
        if (mem_req.req) found = 1'b1;
      end
      check("t3_req_seen", 32'(mem_req.req), 32'd1);
      if ((k % 5) == 4) begin
        check("t3_grant_if", mem_req.addr, 32'h40);
        check("t3_if_sel", 32'(mem_req.sel_byte), 32'hF);
      end else begin
        check("t3_grant_data", mem_req.addr, 32'h300);
        check("t3_wdata", mem_req.w_data, 32'hAABB_CCDD);
        check("t3_sel", 32'(mem_req.sel_byte), 32'h3);
        check("t3_wen", 32'(mem_req.w_en), 32'd1);
      end
    end
    step();
    check("t3_last_if_ack", 32'(if_rsp.ack), 32'd1);
    if_req.req  = 1'b0;
    exe_req.req = 1'b0;
    exe_req     = '0;
    step();

    // 4: slave never acks -> timeout completion and sticky error
    slv_lat          = 0;
    slv_data         = 32'h1234_5678;
    exe_req.addr     = 32'h400;
    exe_req.sel_byte = 4'hF;
    exe_req.req      = 1'b1;
    step();
    check("t4_req", 32'(mem_req.req), 32'd1);
    for (int w = 0; w < 15; w++) begin
      step();
      check("t4_no_early_ack", 32'(exe_rsp.ack), 32'd0);
    end
    step();
    check("t4_tmo_ack", 32'(exe_rsp.ack), 32'd1);
    check("t4_tmo_rdata", exe_rsp.r_data, 32'd0);
    check("t4_err_not_yet", 32'(bus_err), 32'd0);
    exe_req.req = 1'b0;
    step();
    check("t4_err_set", 32'(bus_err), 32'd1);
    check("t4_ack_once", 32'(exe_rsp.ack), 32'd0);
    run_fetch(32'h44, 32'hCAFE_F00D);
    check("t4_err_sticky", 32'(bus_err), 32'd1);

    // 5: reset during WAIT, slave acks the following cycle
    slv_lat     = 3;
    if_req.addr = 32'h80;
    if_req.req  = 1'b1;
    step();
    check("t5_req", 32'(mem_req.req), 32'd1);
    step();
    step();
    rst        = 1'b1;
    if_req.req = 1'b0;
    step();
    rst = 1'b0;
    check("t5_late_slave_ack", 32'(mem_ack), 32'd1);
    check("t5_no_if_ack", 32'(if_rsp.ack), 32'd0);
    check("t5_no_exe_ack", 32'(exe_rsp.ack), 32'd0);
    check("t5_addr_cleared", mem_req.addr, 32'd0);
    check("t5_err_cleared", 32'(bus_err), 32'd0);
    step();
    check("t5_idle", 32'(mem_req.req), 32'd0);
    run_fetch(32'h84, 32'h0000_5A5A);

    // 6: data request not targeting this slave
    dmem_sel     = 1'b0;
    exe_req      = '0;
    exe_req.addr = 32'h500;
    exe_req.req  = 1'b1;
    run_fetch(32'h88, 32'h1357_9BDF);
    for (int c = 0; c < 4; c++) begin
      step();
      check("t6_no_slave_req", 32'(mem_req.req), 32'd0);
      check("t6_no_exe_ack", 32'(exe_rsp.ack), 32'd0);
    end
    exe_req.req = 1'b0;
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
